div_const_seq_ctrl: RTL and testbench
=====================================

// Module: div_const_seq_ctrl
// PURPOSE
//  Iterative divide-by-constant unit for the constant-division family. Sequences one
//  shared chunk stage over the dividend, MSB first, CHUNK bits per cycle.
//  Each step forms t = {rem, chunk}; a LUT-mappable stage (RW+CHUNK inputs, 6 at defaults)
//  produces q_chunk = t / D and the new remainder t % D.
//  Sits between a valid/ready producer and consumer, trading area for latency
//  against the fully unrolled per-bit LUT networks.
// PARAMETERS
//  W      64  dividend/quotient width; W % CHUNK must be 0
//  D      11  constant divisor, 2 <= D < 2**RW
//  CHUNK  2   dividend bits consumed per step
//  RW     4   remainder width = $clog2(D); localparam, not overridable
//  NSTEP  W/CHUNK (32); localparam
// PORTS
//  clk        in   1      sole clock, rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      dividend offered
//  in_ready   out  1      unit can accept a dividend (high only in IDLE)
//  in_x       in   W      dividend, unsigned
//  out_valid  out  1      result held and valid
//  out_ready  in   1      consumer takes result
//  out_q      out  W      quotient floor(in_x / D)
//  out_r      out  RW     remainder in_x % D
//  busy       out  1      high in RUN or DONE
// BEHAVIOUR
//  Reset (rst=1 at clk edge): state=IDLE, in_ready=1, out_valid=0, busy=0,
//   out_q=0, out_r=0, step counter=0. Any operation in flight is discarded.
//  FSM IDLE -> RUN -> DONE -> IDLE.
//  - IDLE: in_ready=1. On in_valid&in_ready: load shift reg xs=in_x, rem=0, q=0,
//    cnt=0; go to RUN. in_x is sampled only on this edge.
//  - RUN: in_ready=0. Each cycle: t={rem, xs[W-1 -:CHUNK]}; rem<=t%D;
//    q<={q[W-CHUNK-1:0], t/D}; xs<=xs<<CHUNK; cnt<=cnt+1.
//    After step NSTEP-1 (cnt==NSTEP-1): go to DONE.
//  - DONE: out_valid=1; out_q and out_r are stable. out_valid stays high until
//    out_ready=1. On out_valid&out_ready, go to IDLE. A new dividend is not
//    accepted in the same cycle; in_ready is low in DONE.
//  Arithmetic: rem<D implies t<D*2**CHUNK, so t/D fits CHUNK bits and t%D fits RW
//   bits. No truncation or overflow is permitted. All values are unsigned.
//  Latency: accept edge to out_valid high is NSTEP+1 edges (33 at defaults).
//   Minimum issue interval is NSTEP+2 cycles.
//  out_q/out_r hold their last result through IDLE until the next DONE. Only
//   out_valid qualifies them.
//  Backpressure: results stay stable indefinitely while out_ready=0.
//  out_ready is ignored outside DONE. in_valid is ignored outside IDLE.
//  Reset mid-RUN or mid-DONE: the next edge gives the reset state. No stale
//   out_valid pulse is produced.
//  cnt width is $clog2(NSTEP); cnt does not wrap within an operation.
// TESTING
//  1 in_x=121, out_ready=1 -> out_q=11, out_r=0; out_valid rises exactly 33 edges after accept.
//  2 in_x=64'hFFFF_FFFF_FFFF_FFFF -> out_q=64'd1676976733973595601, out_r=4.
//  3 in_x=0 -> q=0,r=0; in_x=10 -> q=0,r=10; in_x=11 -> q=1,r=0.
//  4 in_x=1000, out_ready low 20 cycles -> out_valid, q=90, r=10 held stable;
//    in_ready stays 0; accepted on first out_ready=1, then IDLE.
//  5 rst=1 at step 15 of RUN -> next cycle in_ready=1, out_valid=0, busy=0;
//    a subsequent in_x=22 gives q=2, r=0.
//  6 in_valid held high with 200 random dividends -> q*11+r==in_x and r<11 for
//    each; issue interval 34 cycles; scoreboard vs reference model.

Source files
------------

// File: rtl/div_const_seq_ctrl.sv
// Iterative unsigned divide-by-constant: one shared CHUNK-bit stage walks the dividend MSB first.
// Results are registered and stay held until the next operation completes.
module div_const_seq_ctrl #(
  parameter  int W     = 64,
  parameter  int D     = 11,
  parameter  int CHUNK = 2,
  localparam int RW    = $clog2(D),
  localparam int NSTEP = W / CHUNK
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_x,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_q,
  output logic [RW-1:0] out_r,
  output logic          busy
);

  localparam int TW = RW + CHUNK;
  localparam int CW = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam logic [TW-1:0] DIV_V = TW'(D);
  localparam logic [CW-1:0] LAST_CNT = CW'(NSTEP - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_r, state_next_s;
  logic [W-1:0]  xs_r;
  logic [W-1:0]  q_r;
  logic [RW-1:0] rem_r;
  logic [CW-1:0] cnt_r;

  logic [TW-1:0]    t_s;
  logic [CHUNK-1:0] tq_s;
  logic [RW-1:0]    tr_s;
  logic [W-1:0]     q_next_s;

  // Shared chunk stage: since rem < D, t/D fits CHUNK bits and t%D fits RW bits.
  always_comb begin
    t_s      = {rem_r, xs_r[W-1 -: CHUNK]};
    tq_s     = CHUNK'(t_s / DIV_V);
    tr_s     = RW'(t_s % DIV_V);
    q_next_s = {q_r[W-CHUNK-1:0], tq_s};
  end

  // Next-state logic for the IDLE -> RUN -> DONE -> IDLE sequence.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_next_s = RUN;
        else          state_next_s = IDLE;
      end
      RUN: begin
        if (cnt_r == LAST_CNT) state_next_s = DONE;
        else                   state_next_s = RUN;
      end
      DONE: begin
        if (out_ready) state_next_s = IDLE;
        else           state_next_s = DONE;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      xs_r      <= '0;
      q_r       <= '0;
      rem_r     <= '0;
      cnt_r     <= '0;
      out_q     <= '0;
      out_r     <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      in_ready  <= (state_next_s == IDLE);
      out_valid <= (state_next_s == DONE);
      busy      <= (state_next_s != IDLE);
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            xs_r  <= in_x;
            q_r   <= '0;
            rem_r <= '0;
            cnt_r <= '0;
          end else begin
            xs_r  <= xs_r;
          end
        end
        RUN: begin
          rem_r <= tr_s;
          q_r   <= q_next_s;
          xs_r  <= xs_r << CHUNK;
          cnt_r <= cnt_r + CW'(1);
          // The final step publishes straight into the held result registers.
          if (cnt_r == LAST_CNT) begin
            out_q <= q_next_s;
            out_r <= tr_s;
          end else begin
            out_q <= out_q;
          end
        end
        default: begin
          xs_r <= xs_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_const_seq_ctrl.sv
// Self-checking bench for div_const_seq_ctrl (W=64, D=11, CHUNK=2) against plain 64-bit / and %.
module tb_div_const_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_x;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_q;
  logic [3:0]  out_r;
  logic        busy;

  int total = 0;
  int bad   = 0;

  div_const_seq_ctrl #(.W(64), .D(11), .CHUNK(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q), .out_r(out_r), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one dividend, return edges from accept to out_valid (accept edge counted) and result.
  task automatic run_op(input logic [63:0] x, output int lat, output logic [63:0] q, output logic [3:0] r);
    int guard = 0;
    while (!in_ready && guard < 200) begin tick(); guard++; end
    in_valid = 1'b1;
    in_x     = x;
    tick();
    in_valid = 1'b0;
    in_x     = 64'd0;
    lat = 1;
    while (!out_valid && lat < 100) begin tick(); lat++; end
    q = out_q;
    r = out_r;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_x = 64'd0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_q !== 64'd0 || out_r !== 4'd0) begin
      bad++;
      $display("FAIL reset: in_ready=%b out_valid=%b busy=%b q=%0d r=%0d, want 1 0 0 0 0",
               in_ready, out_valid, busy, out_q, out_r);
    end
  endtask

  task automatic test_basic();
    int lat; logic [63:0] q; logic [3:0] r;
    out_ready = 1'b1;
    run_op(64'd121, lat, q, r);
    total++;
    if (lat !== 33) begin bad++; $display("FAIL latency: got %0d want 33", lat); end
    total++;
    if (q !== 64'd11 || r !== 4'd0) begin bad++; $display("FAIL basic_121: q=%0d r=%0d want 11 0", q, r); end
    tick();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL basic_return_idle: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_max();
    int lat; logic [63:0] q; logic [3:0] r;
    logic [63:0] x = 64'hFFFF_FFFF_FFFF_FFFF;
    out_ready = 1'b1;
    run_op(x, lat, q, r);
    tick();
    total++;
    if (q !== 64'd1676976733973595601 || r !== 4'd4) begin
      bad++; $display("FAIL max: q=%0d r=%0d want 1676976733973595601 4", q, r);
    end
  endtask

  task automatic test_small();
    logic [63:0] xs [3] = '{64'd0, 64'd10, 64'd11};
    int lat; logic [63:0] q; logic [3:0] r;
    out_ready = 1'b1;
    foreach (xs[i]) begin
      run_op(xs[i], lat, q, r);
      tick();
      total++;
      if (q !== xs[i] / 64'd11 || {60'd0, r} !== xs[i] % 64'd11 || lat !== 33) begin
        bad++; $display("FAIL small x=%0d: q=%0d r=%0d lat=%0d want %0d %0d 33",
                        xs[i], q, r, lat, xs[i] / 64'd11, xs[i] % 64'd11);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat; logic [63:0] q; logic [3:0] r;
    int held_bad = 0;
    out_ready = 1'b0;
    run_op(64'd1000, lat, q, r);
    total++;
    if (out_valid !== 1'b1 || q !== 64'd90 || r !== 4'd10) begin
      bad++; $display("FAIL bp_first: valid=%b q=%0d r=%0d want 1 90 10", out_valid, q, r);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid !== 1'b1 || out_q !== 64'd90 || out_r !== 4'd10 || in_ready !== 1'b0 || busy !== 1'b1)
        held_bad++;
    end
    total++;
    if (held_bad != 0) begin bad++; $display("FAIL bp_hold: %0d unstable cycles, want 0", held_bad); end
    out_ready = 1'b1;
    tick();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_q !== 64'd90 || out_r !== 4'd10) begin
      bad++; $display("FAIL bp_release: valid=%b in_ready=%b busy=%b q=%0d r=%0d want 0 1 0 90 10",
                      out_valid, in_ready, busy, out_q, out_r);
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic [63:0] q; logic [3:0] r;
    int stale = 0;
    out_ready = 1'b1;
    in_valid = 1'b1; in_x = 64'd987654321;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    total++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      bad++; $display("FAIL mid_run: busy=%b in_ready=%b want 1 0", busy, in_ready);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL mid_reset: in_ready=%b out_valid=%b busy=%b want 1 0 0", in_ready, out_valid, busy);
    end
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid !== 1'b0 || busy !== 1'b0) stale++;
    end
    total++;
    if (stale != 0) begin bad++; $display("FAIL mid_stale: %0d stale cycles, want 0", stale); end
    run_op(64'd22, lat, q, r);
    tick();
    total++;
    if (q !== 64'd2 || r !== 4'd0 || lat !== 33) begin
      bad++; $display("FAIL after_reset_22: q=%0d r=%0d lat=%0d want 2 0 33", q, r, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp_q [$];
    logic [63:0] x, e;
    int acc = 0, got = 0, cyc = 0, last_acc = -1;
    int gap_bad = 0, res_bad = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    while (got < 200 && cyc < 9000) begin
      if (in_ready) begin
        if (acc < 200) begin
          case ($urandom_range(3, 0))
            0:       x = 64'($urandom_range(40, 0));
            1:       x = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(40, 0));
            default: x = {$urandom, $urandom};
          endcase
          in_x = x;
          exp_q.push_back(x);
          if (last_acc >= 0 && cyc - last_acc != 34) begin
            gap_bad++;
            if (gap_bad < 4) $display("FAIL b2b_interval: got %0d want 34", cyc - last_acc);
          end
          last_acc = cyc;
          acc++;
        end else begin
          in_valid = 1'b0;
        end
      end
      tick();
      cyc++;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          res_bad++;
          $display("FAIL b2b_spurious: out_valid with nothing issued");
        end else begin
          e = exp_q.pop_front();
          if (out_q !== e / 64'd11 || {60'd0, out_r} !== e % 64'd11 ||
              out_q * 64'd11 + {60'd0, out_r} !== e || out_r >= 4'd11) begin
            res_bad++;
            if (res_bad < 4) $display("FAIL b2b_result x=%0d: q=%0d r=%0d want %0d %0d",
                                      e, out_q, out_r, e / 64'd11, e % 64'd11);
          end
        end
        got++;
      end
    end
    in_valid = 1'b0;
    total++;
    if (gap_bad != 0) begin bad++; $display("FAIL b2b_intervals: %0d wrong gaps, want 0", gap_bad); end
    total++;
    if (res_bad != 0) begin bad++; $display("FAIL b2b_results: %0d wrong results, want 0", res_bad); end
    total++;
    if (got != 200) begin bad++; $display("FAIL b2b_count: got %0d results want 200", got); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_small();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
